muskbus_line_writer: RTL

Parametrised successor to the single-shot Muskbus line writer. It accepts cache-line write requests from up to N_SRC requesters and queues them in a FIFO. Each queued request is serialised onto Muskbus as one address header beat followed by LINE_BITS/BUS_BITS data beats. It sits between the writeback paths (D-cache, page walker) and the Muskbus.Top arbitration port.

---
 rtl/muskbus_line_writer_pkg.sv | 17 +
 rtl/muskbus_line_writer_if.sv | 29 ++
 rtl/muskbus_wr_fifo.sv | 59 +++++
 rtl/muskbus_line_writer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muskbus_line_writer_pkg.sv
// Muskbus line writer shared definitions.
// Contents:
//   TAG_W          - width of the Muskbus request tag field
//   WRITE_MEM_TAG  - tag presented on reqtag for every header and data beat of a line write
//   writer_state_t - writer sequencing states (IDLE, HDR, DATA)
package muskbus_line_writer_pkg;

  localparam int TAG_W = 4;
  localparam logic [TAG_W-1:0] WRITE_MEM_TAG = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } writer_state_t;

endpackage

// File: rtl/muskbus_line_writer_if.sv
// Muskbus request port (the Muskbus.Top arbitration side).
// Signals:
//   bid     - writer is bidding for / owns the bus
//   reqcyc  - request cycle valid
//   reqtag  - request type tag
//   req     - header address or data beat, BUS_BITS wide
//   reqack  - arbiter accepts the header beat
//   respack - response acknowledge, never used by a writer (held 0)
// Modports: master (the writer), slave (the arbitration port).
interface muskbus_line_writer_if #(
  parameter int BUS_BITS = 64
);
  logic                                       bid;
  logic                                       reqcyc;
  logic [muskbus_line_writer_pkg::TAG_W-1:0]  reqtag;
  logic [BUS_BITS-1:0]                        req;
  logic                                       reqack;
  logic                                       respack;

  modport master (
    output bid, reqcyc, reqtag, req, respack,
    input  reqack
  );

  modport slave (
    input  bid, reqcyc, reqtag, req, respack,
    output reqack
  );
endinterface

// File: rtl/muskbus_wr_fifo.sv
// Generic synchronous FIFO for pending line-write requests.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data     - write an entry (honoured when not full, or when popping the same cycle)
//   pop, pop_data       - head entry is visible on pop_data; pop removes it (ignored when empty)
//   full, empty         - occupancy flags
// DEPTH must be a power of two, at least 2.
module muskbus_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot being written this same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // The writer latches the head in the cycle it pops, so the read is not registered.
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/muskbus_line_writer.sv
// Muskbus line writer: accepts cache-line writes from N_SRC requesters (fixed priority,
// lowest index wins), queues them, and serialises each as one address header beat followed
// by LINE_BITS/BUS_BITS data beats (beat 0 = bits [0 +: BUS_BITS]).
// Ports:
//   clk, reset  - clock, asynchronous active-low reset (aborts transfer, flushes queue)
//   bus         - Muskbus master side: bid/reqcyc/reqtag/req driven, reqack sampled
//   wr_valid    - per-source request valid
//   wr_ready    - per-source accept, at most one bit set
//   wr_addr     - per-source 64-bit line address
//   wr_data     - per-source line payload
//   done        - one-cycle pulse coincident with the last data beat
//   done_src    - source index of the completed line
//   busy        - queue non-empty or a line in flight
// Optional build macro MUSKBUS_WRITER_PERF_EN adds saturating counters perf_lines,
// perf_hdr_wait and perf_full.
module muskbus_line_writer
  import muskbus_line_writer_pkg::*;
#(
  parameter  int BUS_BITS  = 64,
  parameter  int LINE_BITS = 512,
  parameter  int DEPTH     = 4,
  parameter  int N_SRC     = 2,
  localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  muskbus_line_writer_if.master        bus,
  input  logic [N_SRC-1:0]             wr_valid,
  output logic [N_SRC-1:0]             wr_ready,
  input  logic [N_SRC*64-1:0]          wr_addr,
  input  logic [N_SRC*LINE_BITS-1:0]   wr_data,
  output logic                         done,
  output logic [SRC_W-1:0]             done_src,
  output logic                         busy
`ifdef MUSKBUS_WRITER_PERF_EN
  ,
  output logic [31:0]                  perf_lines,
  output logic [31:0]                  perf_hdr_wait,
  output logic [31:0]                  perf_full
`endif
);
  localparam int BEATS  = LINE_BITS / BUS_BITS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef struct packed {
    logic [SRC_W-1:0]     src;
    logic [63:0]          addr;
    logic [LINE_BITS-1:0] data;
  } line_t;

  writer_state_t         state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  line_t                 line_q, line_d;
  logic                  bid_q, bid_d;
  logic [BUS_BITS-1:0]   req_q, req_d;
  logic                  done_q, done_d;
  logic [SRC_W-1:0]      done_src_q, done_src_d;

  line_t                 push_line, head_line;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  accept_ok;
  logic [N_SRC:0]        lower_valid;
  logic [SRC_W-1:0]      sel_src;

  // Head is consumed from IDLE, or on the last data beat for back-to-back lines.
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || (state_q == DATA && beat_q == LAST_BEAT));
  assign accept_ok = !fifo_full || fifo_pop;

  // Fixed-priority grant: a source is granted only if no lower index is valid.
  assign lower_valid[0] = 1'b0;
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_arb
    assign lower_valid[gi+1] = lower_valid[gi] | wr_valid[gi];
    assign wr_ready[gi]      = wr_valid[gi] & ~lower_valid[gi] & accept_ok;
  end
  assign fifo_push = lower_valid[N_SRC] & accept_ok;

  always_comb begin
    sel_src = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (wr_valid[i]) sel_src = SRC_W'(i);
    end
  end

  assign push_line.src  = sel_src;
  assign push_line.addr = wr_addr[int'(sel_src)*64 +: 64];
  assign push_line.data = wr_data[int'(sel_src)*LINE_BITS +: LINE_BITS];

  muskbus_wr_fifo #(
    .WIDTH ($bits(line_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (push_line),
    .pop       (fifo_pop),
    .pop_data  (head_line),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          state_d = HDR;
          line_d  = head_line;
        end
      end
      HDR: begin
        if (bus.reqack) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (fifo_pop) begin
            state_d = HDR;
            line_d  = head_line;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are decoded from the next state so they are registered, not combinational.
    bid_d = (state_d != IDLE);
    req_d = '0;
    if (state_d == HDR) begin
      req_d = BUS_BITS'(line_d.addr);
    end else if (state_d == DATA) begin
      req_d = line_d.data[int'(beat_d)*BUS_BITS +: BUS_BITS];
    end
    done_d     = (state_d == DATA) && (beat_d == LAST_BEAT);
    done_src_d = done_d ? line_d.src : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      bid_q      <= 1'b0;
      req_q      <= '0;
      done_q     <= 1'b0;
      done_src_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      bid_q      <= bid_d;
      req_q      <= req_d;
      done_q     <= done_d;
      done_src_q <= done_src_d;
    end
  end

  assign bus.bid     = bid_q;
  assign bus.reqcyc  = bid_q;
  assign bus.reqtag  = bid_q ? WRITE_MEM_TAG : '0;
  assign bus.req     = req_q;
  assign bus.respack = 1'b0;
  assign done        = done_q;
  assign done_src    = done_src_q;
  assign busy        = !fifo_empty || (state_q != IDLE);

`ifdef MUSKBUS_WRITER_PERF_EN
  logic [31:0] perf_lines_q, perf_lines_d;
  logic [31:0] perf_hdr_wait_q, perf_hdr_wait_d;
  logic [31:0] perf_full_q, perf_full_d;

  always_comb begin
    perf_lines_d    = perf_lines_q;
    perf_hdr_wait_d = perf_hdr_wait_q;
    perf_full_d     = perf_full_q;
    if (done_q && perf_lines_q != '1)
      perf_lines_d = perf_lines_q + 32'd1;
    if (state_q == HDR && !bus.reqack && perf_hdr_wait_q != '1)
      perf_hdr_wait_d = perf_hdr_wait_q + 32'd1;
    if (fifo_full && (|wr_valid) && perf_full_q != '1)
      perf_full_d = perf_full_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_lines_q    <= '0;
      perf_hdr_wait_q <= '0;
      perf_full_q     <= '0;
    end else begin
      perf_lines_q    <= perf_lines_d;
      perf_hdr_wait_q <= perf_hdr_wait_d;
      perf_full_q     <= perf_full_d;
    end
  end

  assign perf_lines    = perf_lines_q;
  assign perf_hdr_wait = perf_hdr_wait_q;
  assign perf_full     = perf_full_q;
`endif
endmodule
